ant_batch_draw: RTL and testbench

//  Parametrised, multi-ant successor to the single-ant draw sequencer.
//  On start, it walks NUM_ANTS ants. For each ant it:
//   - reads the x and y words from memory through the datapath handshake;
//   - optionally erases the ant's previous pixel;
//   - plots the new pixel.

---
 rtl/ant_batch_draw_pkg.sv | 36 +++
 rtl/ant_batch_draw_pos_store.sv | 47 ++++
 rtl/ant_batch_draw.sv | 202 ++++++++++++++++++++
 tb/tb_ant_batch_draw.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ant_batch_draw_pkg.sv
// Shared constants for the multi-ant draw sequencer: datapath opcodes,
// instruction field widths and the sequencer state encoding.
package ant_batch_draw_pkg;

    localparam logic [3:0] OPC_LOAD = 4'd2;
    localparam logic [3:0] OPC_DRAW = 4'd1;
    localparam int         OPC_W    = 4;
    localparam int         PLOT_W   = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ISSUE_X,
        S_WAIT_X,
        S_ISSUE_Y,
        S_WAIT_Y,
        S_CHECK,
        S_ISSUE_ERASE,
        S_WAIT_ERASE,
        S_ISSUE_DRAW,
        S_WAIT_DRAW,
        S_NEXT,
        S_DONE
    } state_t;

    // Zero padding between the opcode and the address of a LOAD word.
    function automatic int load_pad_w(input int instr_w, input int addr_w);
        return instr_w - OPC_W - addr_w;
    endfunction

    // Zero padding between the opcode and the plot bit of a DRAW word.
    function automatic int draw_pad_w(input int instr_w, input int colour_w,
                                      input int y_w, input int x_w);
        return instr_w - OPC_W - PLOT_W - colour_w - y_w - x_w;
    endfunction

endpackage

// File: rtl/ant_batch_draw_pos_store.sv
// Per-ant record of the last plotted position: {valid, x, y} per ant,
// one synchronous write port, one asynchronous read port, cleared on reset.
// Depth is rounded up to the full index range so any index value is legal.
module ant_pos_store #(
    parameter int IDX_W = 4,
    parameter int X_W   = 8,
    parameter int Y_W   = 7
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_valid,
    input  logic [X_W-1:0]   wr_x,
    input  logic [Y_W-1:0]   wr_y,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [X_W-1:0]   rd_x,
    output logic [Y_W-1:0]   rd_y
);

    localparam int DEPTH = 2 ** IDX_W;

    logic           valid_q [DEPTH];
    logic [X_W-1:0] x_q     [DEPTH];
    logic [Y_W-1:0] y_q     [DEPTH];

    // Clear every entry on reset, otherwise write one entry when requested.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
            end
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_valid;
            x_q[wr_idx]     <= wr_x;
            y_q[wr_idx]     <= wr_y;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_x     = x_q[rd_idx];
    assign rd_y     = y_q[rd_idx];

endmodule

// File: rtl/ant_batch_draw.sv
// Multi-ant draw sequencer: for every ant it loads x and y through the
// shared datapath, optionally erases the previous pixel, then plots the new one.
module ant_batch_draw
    import ant_batch_draw_pkg::*;
#(
    parameter int                  NUM_ANTS   = 8,
    parameter int                  ADDR_W     = 16,
    parameter int                  INSTR_W    = 32,
    parameter int                  RESULT_W   = 32,
    parameter int                  X_W        = 8,
    parameter int                  Y_W        = 7,
    parameter int                  COLOUR_W   = 3,
    parameter int                  SCREEN_W   = 160,
    parameter int                  SCREEN_H   = 120,
    parameter logic [COLOUR_W-1:0] ANT_COLOUR = 3'b010,
    parameter logic [COLOUR_W-1:0] BG_COLOUR  = 3'b000
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic                erase_en,
    input  logic [ADDR_W-1:0]   base_x_address,
    input  logic [ADDR_W-1:0]   base_y_address,
    output logic                busy,
    output logic                finished,
    output logic [7:0]          drawn_count,
    output logic                start_dp,
    output logic [INSTR_W-1:0]  instruction_dp,
    input  logic                finished_dp,
    input  logic [RESULT_W-1:0] result_dp
);

    localparam int IDX_W      = $clog2(NUM_ANTS + 1);
    localparam int LOAD_PAD_W = load_pad_w(INSTR_W, ADDR_W);
    localparam int DRAW_PAD_W = draw_pad_w(INSTR_W, COLOUR_W, Y_W, X_W);

    function automatic logic [INSTR_W-1:0] make_load(input logic [ADDR_W-1:0] addr);
        return {OPC_LOAD, {LOAD_PAD_W{1'b0}}, addr};
    endfunction

    function automatic logic [INSTR_W-1:0] make_draw(input logic [COLOUR_W-1:0] colour,
                                                     input logic [Y_W-1:0] y,
                                                     input logic [X_W-1:0] x);
        return {OPC_DRAW, {DRAW_PAD_W{1'b0}}, 1'b1, colour, y, x};
    endfunction

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_next;
    logic                erase_q;
    logic [ADDR_W-1:0]   base_x_q;
    logic [ADDR_W-1:0]   base_y_q;
    logic [RESULT_W-1:0] x_full;
    logic [RESULT_W-1:0] y_full;
    logic                in_range;
    logic                last_ant;
    logic                do_erase;
    logic                prev_valid;
    logic [X_W-1:0]      prev_x;
    logic [Y_W-1:0]      prev_y;
    logic                wr_en;
    logic                wr_valid;

    // Bounds are checked on the full loaded word so high garbage bits count as off-screen.
    assign in_range = (x_full < RESULT_W'(SCREEN_W)) && (y_full < RESULT_W'(SCREEN_H));
    assign last_ant = (idx == IDX_W'(NUM_ANTS - 1));
    assign idx_next = idx + IDX_W'(1);
    assign do_erase = erase_q && prev_valid;

    // Record the plotted position, or forget it when the ant leaves the screen.
    always_comb begin
        wr_en    = 1'b0;
        wr_valid = 1'b0;
        if (state == S_WAIT_DRAW && finished_dp) begin
            wr_en    = 1'b1;
            wr_valid = 1'b1;
        end else if (state == S_CHECK && !do_erase && !in_range) begin
            wr_en = 1'b1;
        end else if (state == S_WAIT_ERASE && finished_dp && !in_range) begin
            wr_en = 1'b1;
        end
    end

    ant_pos_store #(
        .IDX_W (IDX_W),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_pos_store (
        .clock    (clock),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_idx   (idx),
        .wr_valid (wr_valid),
        .wr_x     (x_full[X_W-1:0]),
        .wr_y     (y_full[Y_W-1:0]),
        .rd_idx   (idx),
        .rd_valid (prev_valid),
        .rd_x     (prev_x),
        .rd_y     (prev_y)
    );

    // Sequencer: each request is raised on entry to an ISSUE state so start_dp covers exactly that cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            finished       <= 1'b0;
            drawn_count    <= 8'd0;
            start_dp       <= 1'b0;
            instruction_dp <= '0;
            idx            <= '0;
            erase_q        <= 1'b0;
            base_x_q       <= '0;
            base_y_q       <= '0;
            x_full         <= '0;
            y_full         <= '0;
        end else begin
            start_dp <= 1'b0;
            finished <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        busy           <= 1'b1;
                        drawn_count    <= 8'd0;
                        idx            <= '0;
                        erase_q        <= erase_en;
                        base_x_q       <= base_x_address;
                        base_y_q       <= base_y_address;
                        start_dp       <= 1'b1;
                        instruction_dp <= make_load(base_x_address);
                        state          <= S_ISSUE_X;
                    end
                end
                S_ISSUE_X: state <= S_WAIT_X;
                S_WAIT_X: begin
                    if (finished_dp) begin
                        x_full         <= result_dp;
                        start_dp       <= 1'b1;
                        instruction_dp <= make_load(base_y_q + ADDR_W'(idx));
                        state          <= S_ISSUE_Y;
                    end
                end
                S_ISSUE_Y: state <= S_WAIT_Y;
                S_WAIT_Y: begin
                    if (finished_dp) begin
                        y_full <= result_dp;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (do_erase) begin
                        start_dp       <= 1'b1;
                        instruction_dp <= make_draw(BG_COLOUR, prev_y, prev_x);
                        state          <= S_ISSUE_ERASE;
                    end else if (in_range) begin
                        start_dp       <= 1'b1;
                        instruction_dp <= make_draw(ANT_COLOUR, y_full[Y_W-1:0], x_full[X_W-1:0]);
                        state          <= S_ISSUE_DRAW;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_ISSUE_ERASE: state <= S_WAIT_ERASE;
                S_WAIT_ERASE: begin
                    if (finished_dp) begin
                        if (in_range) begin
                            start_dp       <= 1'b1;
                            instruction_dp <= make_draw(ANT_COLOUR, y_full[Y_W-1:0], x_full[X_W-1:0]);
                            state          <= S_ISSUE_DRAW;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                end
                S_ISSUE_DRAW: state <= S_WAIT_DRAW;
                S_WAIT_DRAW: begin
                    if (finished_dp) begin
                        if (drawn_count != 8'hFF) begin
                            drawn_count <= drawn_count + 8'd1;
                        end
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (last_ant) begin
                        busy     <= 1'b0;
                        finished <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        idx            <= idx_next;
                        start_dp       <= 1'b1;
                        instruction_dp <= make_load(base_x_q + ADDR_W'(idx_next));
                        state          <= S_ISSUE_X;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ant_batch_draw.sv
// Bench for ant_batch_draw: a behavioural datapath with programmable latency
// answers requests from a small memory, and a scoreboard queue holds the
// instruction stream a reference model predicts for each batch.
module tb_ant_batch_draw;

    localparam int NA = 4;

    typedef struct {
        bit               erase;
        logic [15:0]      bx;
        logic [15:0]      by;
        logic [3:0][31:0] xs;
        logic [3:0][31:0] ys;
        int               lat;
        bit               sticky;
        bit               poke;
        int               exp_req;
        int               exp_drawn;
    } vec_t;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic        erase_en;
    logic [15:0] base_x_address;
    logic [15:0] base_y_address;
    logic        busy;
    logic        finished;
    logic [7:0]  drawn_count;
    logic        start_dp;
    logic [31:0] instruction_dp;
    logic        finished_dp;
    logic [31:0] result_dp;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem [logic [15:0]];
    int          lat = 3;
    bit          sticky = 1'b0;
    int          dp_cnt = 0;
    bit          pending = 1'b0;
    int          req_count = 0;
    int          fin_count = 0;
    logic [31:0] cur_instr = '0;
    bit          m_valid [NA];
    logic [7:0]  m_x [NA];
    logic [6:0]  m_y [NA];
    vec_t        vecs [8];

    ant_batch_draw #(.NUM_ANTS(NA)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .start          (start),
        .erase_en       (erase_en),
        .base_x_address (base_x_address),
        .base_y_address (base_y_address),
        .busy           (busy),
        .finished       (finished),
        .drawn_count    (drawn_count),
        .start_dp       (start_dp),
        .instruction_dp (instruction_dp),
        .finished_dp    (finished_dp),
        .result_dp      (result_dp)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    function automatic logic [31:0] mk_load(input logic [15:0] a);
        return {4'd2, 12'd0, a};
    endfunction

    function automatic logic [31:0] mk_draw(input logic [2:0] c, input logic [6:0] y, input logic [7:0] x);
        return {4'd1, 9'd0, 1'b1, c, y, x};
    endfunction

    function automatic vec_t mkv(input bit e, input logic [15:0] bx, input logic [15:0] by,
                                 input logic [3:0][31:0] xs, input logic [3:0][31:0] ys,
                                 input int l, input bit st, input bit pk, input int rq, input int dr);
        vec_t v;
        v.erase = e; v.bx = bx; v.by = by; v.xs = xs; v.ys = ys;
        v.lat = l; v.sticky = st; v.poke = pk; v.exp_req = rq; v.exp_drawn = dr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=timeout required=event", name);
    endtask

    // Datapath model and output monitor, acting 1 unit after each rising edge.
    initial begin
        logic [31:0] expv;
        logic [15:0] a;
        finished_dp = 1'b0;
        result_dp   = '0;
        forever begin
            @(posedge clock);
            #1;
            if (!resetn) begin
                dp_cnt      = 0;
                pending     = 1'b0;
                finished_dp = 1'b0;
            end else begin
                if (finished) begin
                    fin_count++;
                    checkOutput("busy_low_in_done", busy, 1'b0);
                end
                if (pending) begin
                    checkOutput("instr_stable", instruction_dp, cur_instr);
                    dp_cnt--;
                    if (dp_cnt == 0) begin
                        pending     = 1'b0;
                        finished_dp = 1'b1;
                        a           = cur_instr[15:0];
                        if (cur_instr[31:28] == 4'd2 && mem.exists(a)) result_dp = mem[a];
                        else result_dp = 32'h0;
                    end else begin
                        finished_dp = 1'b0;
                    end
                end else if (!sticky) begin
                    finished_dp = 1'b0;
                end
                if (start_dp) begin
                    req_count++;
                    if (pending) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL dp_overlap actual=%0h required=idle", instruction_dp);
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_req actual=%0h required=none", instruction_dp);
                    end else begin
                        expv = exp_q.pop_front();
                        checkOutput("dp_request", instruction_dp, expv);
                    end
                    cur_instr = instruction_dp;
                    dp_cnt    = lat;
                    pending   = 1'b1;
                end
            end
        end
    end

    // Reference model: push the expected request stream for one batch and update prior positions.
    task automatic predictBatch(input vec_t v);
        bit inr;
        for (int i = 0; i < NA; i++) begin
            exp_q.push_back(mk_load(16'(v.bx + 16'(i))));
            exp_q.push_back(mk_load(16'(v.by + 16'(i))));
            inr = (v.xs[i] < 32'd160) && (v.ys[i] < 32'd120);
            if (v.erase && m_valid[i]) exp_q.push_back(mk_draw(3'b000, m_y[i], m_x[i]));
            if (inr) begin
                exp_q.push_back(mk_draw(3'b010, v.ys[i][6:0], v.xs[i][7:0]));
                m_valid[i] = 1'b1;
                m_x[i]     = v.xs[i][7:0];
                m_y[i]     = v.ys[i][6:0];
            end else begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int fin0, req0, cyc;
        for (int i = 0; i < NA; i++) begin
            mem[16'(v.bx + 16'(i))] = v.xs[i];
            mem[16'(v.by + 16'(i))] = v.ys[i];
        end
        lat    = v.lat;
        sticky = v.sticky;
        predictBatch(v);
        fin0 = fin_count;
        req0 = req_count;
        @(negedge clock);
        start          = 1'b1;
        erase_en       = v.erase;
        base_x_address = v.bx;
        base_y_address = v.by;
        @(negedge clock);
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1'b1);
        erase_en       = ~v.erase;
        base_x_address = 16'h5555;
        base_y_address = 16'hAAAA;
        cyc = 0;
        while (!finished && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            start = (v.poke && cyc == 4);
        end
        start = 1'b0;
        if (cyc >= 2000) failNow("batch_finish");
        checkOutput("drawn_count", drawn_count, v.exp_drawn);
        if (v.poke) start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checkOutput("finished_one_cycle", finished, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("busy_idle", busy, 1'b0);
        checkOutput("finished_pulses", fin_count - fin0, 1);
        checkOutput("req_count", req_count - req0, v.exp_req);
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("drawn_count_hold", drawn_count, v.exp_drawn);
    endtask

    task automatic resetMidBatch();
        int fin0, req0, cyc;
        lat    = 3;
        sticky = 1'b0;
        exp_q.push_back(mk_load(16'h0100));
        exp_q.push_back(mk_load(16'h0200));
        fin0 = fin_count;
        req0 = req_count;
        @(negedge clock);
        start          = 1'b1;
        erase_en       = 1'b1;
        base_x_address = 16'h0100;
        base_y_address = 16'h0200;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        while (req_count - req0 < 2 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        if (cyc >= 50) failNow("reach_wait_y");
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_finished", finished, 1'b0);
        checkOutput("rst_start_dp", start_dp, 1'b0);
        checkOutput("rst_instruction", instruction_dp, 32'h0);
        checkOutput("rst_drawn", drawn_count, 8'd0);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < NA; i++) m_valid[i] = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        checkOutput("rst_no_finish", fin_count - fin0, 0);
        checkOutput("rst_idle", busy, 1'b0);
    endtask

    // Main sequence: reset, the vector table, and a mid-batch reset before the last vector.
    initial begin
        resetn         = 1'b0;
        start          = 1'b0;
        erase_en       = 1'b0;
        base_x_address = '0;
        base_y_address = '0;
        for (int i = 0; i < NA; i++) begin
            m_valid[i] = 1'b0;
            m_x[i]     = '0;
            m_y[i]     = '0;
        end
        vecs[0] = mkv(0, 16'h0100, 16'h0200, {32'd40, 32'd30, 32'd20, 32'd10}, {32'd8, 32'd7, 32'd6, 32'd5}, 3, 0, 0, 12, 4);
        vecs[1] = mkv(1, 16'h0100, 16'h0200, {32'd40, 32'd30, 32'd20, 32'd11}, {32'd8, 32'd7, 32'd6, 32'd5}, 3, 0, 1, 16, 4);
        vecs[2] = mkv(1, 16'h0100, 16'h0200, {32'd40, 32'd200, 32'd20, 32'd11}, {32'd8, 32'd7, 32'd6, 32'd5}, 1, 1, 0, 15, 3);
        vecs[3] = mkv(1, 16'h0100, 16'h0200, {32'd40, 32'd30, 32'd20, 32'd11}, {32'd8, 32'd7, 32'd6, 32'd5}, 2, 0, 0, 15, 4);
        vecs[4] = mkv(0, 16'h0100, 16'h0200, {32'd159, 32'd0, 32'd160, 32'd159}, {32'd0, 32'd120, 32'd0, 32'd119}, 1, 0, 0, 10, 2);
        vecs[5] = mkv(1, 16'h0100, 16'h0200, {32'd3, 32'd2, 32'd1, 32'h0100000A}, {32'd3, 32'd2, 32'd1, 32'd5}, 2, 1, 1, 13, 3);
        vecs[6] = mkv(0, 16'hFFFF, 16'h0300, {32'd4, 32'd3, 32'd2, 32'd1}, {32'h80000004, 32'd3, 32'd2, 32'd1}, 1, 1, 0, 11, 3);
        vecs[7] = mkv(1, 16'h0100, 16'h0200, {32'd40, 32'd30, 32'd20, 32'd10}, {32'd8, 32'd7, 32'd6, 32'd5}, 2, 0, 0, 12, 4);

        @(negedge clock);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_finished", finished, 1'b0);
        checkOutput("reset_start_dp", start_dp, 1'b0);
        checkOutput("reset_instruction", instruction_dp, 32'h0);
        checkOutput("reset_drawn", drawn_count, 8'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            if (i == 7) resetMidBatch();
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
